// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and trap sequencing controller.
//
// Resolves stalls, flushes and fetch redirects for a simple in-order pipeline
// from the decode/execute/memory status. Traps drain older instructions for
// DRAIN_CYCLES cycles (legal range 1..15) before jumping to trap_vector.
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   id_rs1, id_rs2              decode source registers
//   ex_rd, ex_mem_read          execute destination / load flag
//   ex_redirect(_target)        taken branch/jump resolved in execute
//   ex_trap, ex_trap_cause      trap raised by the execute instruction
//   ex_pc, trap_vector          faulting PC and trap handler base
//   mem_busy                    memory stage not ready
//   stall_*/flush_*             per-stage hold / NOP-insert controls
//   pc_load, pc_target          fetch redirect (pc_target is 0 when idle)
//   trap_taken                  one-cycle pulse on the trap redirect
//   trap_cause_out, trap_epc    captured trap information
//   stall_cycles                saturating count of stall_if cycles
//   state                       FSM state for debug
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | normal flow; trap > mem_busy > redirect > load-use
// MEM_WAIT   | memory busy, whole front end frozen until mem_busy drops
// TRAP_DRAIN | older instructions drain, younger ones flushed
// TRAP_JUMP  | single-cycle redirect to trap_vector

module hazard_ctrl #(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic [XLEN-1:0]  ex_redirect_target,
    input  logic             ex_trap,
    input  logic [3:0]       ex_trap_cause,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             mem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             pc_load,
    output logic [XLEN-1:0]  pc_target,
    output logic             trap_taken,
    output logic [3:0]       trap_cause_out,
    output logic [XLEN-1:0]  trap_epc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_MEM_WAIT   = 2'd1,
        S_TRAP_DRAIN = 2'd2,
        S_TRAP_JUMP  = 2'd3
    } state_t;

    localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic [XLEN-1:0]   trap_epc_q, trap_epc_d;
    logic [3:0]        trap_cause_q, trap_cause_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        trap_epc_d   = trap_epc_q;
        trap_cause_d = trap_cause_q;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        pc_load      = 1'b0;
        pc_target    = '0;
        trap_taken   = 1'b0;

        // All combinational outputs stay quiet while reset is held; the
        // register side is cleared by the always_ff below.
        if (!reset) begin
            unique case (state_q)
                S_RUN: begin
                    if (ex_trap) begin
                        stall_if     = 1'b1;
                        flush_id     = 1'b1;
                        flush_ex     = 1'b1;
                        trap_epc_d   = ex_pc;
                        trap_cause_d = ex_trap_cause;
                        drain_cnt_d  = DRAIN_INIT;
                        state_d      = S_TRAP_DRAIN;
                    end else if (mem_busy) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                        state_d  = S_MEM_WAIT;
                    end else if (ex_redirect) begin
                        pc_load   = 1'b1;
                        pc_target = ex_redirect_target;
                        flush_if  = 1'b1;
                        flush_id  = 1'b1;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        flush_id = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    // Trap/redirect are ignored here: the frozen execute
                    // instruction presents them again once back in RUN.
                    stall_if = mem_busy;
                    stall_id = mem_busy;
                    stall_ex = mem_busy;
                    if (!mem_busy) begin
                        state_d = S_RUN;
                    end
                end
                S_TRAP_DRAIN: begin
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    if (!mem_busy) begin
                        if (drain_cnt_q == 4'd0) begin
                            state_d = S_TRAP_JUMP;
                        end else begin
                            drain_cnt_d = drain_cnt_q - 4'd1;
                        end
                    end
                end
                S_TRAP_JUMP: begin
                    pc_load    = 1'b1;
                    pc_target  = trap_vector;
                    trap_taken = 1'b1;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    flush_ex   = 1'b1;
                    state_d    = S_RUN;
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // Saturating performance counter: holds at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            drain_cnt_q  <= 4'd0;
            trap_epc_q   <= '0;
            trap_cause_q <= 4'd0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            trap_epc_q   <= trap_epc_d;
            trap_cause_q <= trap_cause_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign trap_cause_out = trap_cause_q;
    assign trap_epc       = trap_epc_q;
    assign stall_cycles   = stall_cnt_q;
    assign state          = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int XLEN  = 64;
    localparam int DRAIN = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            ex_mem_read, ex_redirect, ex_trap, mem_busy;
    logic [XLEN-1:0] ex_redirect_target, ex_pc, trap_vector;
    logic [3:0]      ex_trap_cause;

    logic            stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex;
    logic            pc_load, trap_taken;
    logic [XLEN-1:0] pc_target, trap_epc;
    logic [3:0]      trap_cause_out;
    logic [31:0]     stall_cycles;
    logic [1:0]      state;

    logic            s_stall_if, s_stall_id, s_stall_ex, s_flush_if, s_flush_id, s_flush_ex;
    logic            s_pc_load, s_trap_taken;
    logic [XLEN-1:0] s_pc_target, s_trap_epc;
    logic [3:0]      s_trap_cause_out;
    logic [3:0]      s_stall_cycles;
    logic [1:0]      s_state;

    always #5 clk = ~clk;

    hazard_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .ex_redirect_target(ex_redirect_target), .ex_trap(ex_trap),
        .ex_trap_cause(ex_trap_cause), .ex_pc(ex_pc), .trap_vector(trap_vector),
        .mem_busy(mem_busy), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex), .pc_load(pc_load),
        .pc_target(pc_target), .trap_taken(trap_taken), .trap_cause_out(trap_cause_out),
        .trap_epc(trap_epc), .stall_cycles(stall_cycles), .state(state));

    hazard_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .ex_redirect_target(ex_redirect_target), .ex_trap(ex_trap),
        .ex_trap_cause(ex_trap_cause), .ex_pc(ex_pc), .trap_vector(trap_vector),
        .mem_busy(mem_busy), .stall_if(s_stall_if), .stall_id(s_stall_id),
        .stall_ex(s_stall_ex), .flush_if(s_flush_if), .flush_id(s_flush_id),
        .flush_ex(s_flush_ex), .pc_load(s_pc_load), .pc_target(s_pc_target),
        .trap_taken(s_trap_taken), .trap_cause_out(s_trap_cause_out),
        .trap_epc(s_trap_epc), .stall_cycles(s_stall_cycles), .state(s_state));

    typedef struct {
        logic            rst;
        logic [4:0]      rs1, rs2, rd;
        logic            mr, redir, trap, busy;
        logic [XLEN-1:0] tgt, pc, vec;
        logic [3:0]      cause;
    } in_t;

    typedef struct {
        in_t             i;
        logic [7:0]      ef;   // {sif,sid,sex,fif,fid,fex,pc_load,trap_taken}
        logic [XLEN-1:0] et;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference: pipeline mode per the rules, remaining drain cycles,
    // captured trap info and an unbounded stall count.
    int              m_state;
    int              m_drain_left;
    logic [XLEN-1:0] m_epc;
    logic [3:0]      m_cause;
    longint          m_cnt;

    logic [7:0]      last_flags;
    logic [XLEN-1:0] last_tgt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t i;
        i.rst = 1'b0; i.rs1 = 5'd1; i.rs2 = 5'd2; i.rd = 5'd3;
        i.mr = 1'b0; i.redir = 1'b0; i.trap = 1'b0; i.busy = 1'b0;
        i.tgt = 64'h4000; i.pc = 64'h200; i.vec = 64'h1000; i.cause = 4'd0;
        return i;
    endfunction

    task automatic drive(input in_t i);
        reset = i.rst; id_rs1 = i.rs1; id_rs2 = i.rs2; ex_rd = i.rd;
        ex_mem_read = i.mr; ex_redirect = i.redir; ex_trap = i.trap;
        mem_busy = i.busy; ex_redirect_target = i.tgt; ex_pc = i.pc;
        trap_vector = i.vec; ex_trap_cause = i.cause;
    endtask

    task automatic model_comb(input in_t i, output logic [7:0] f, output logic [XLEN-1:0] t);
        bit lu;
        f = 8'h00; t = '0;
        lu = i.mr && i.rd != 0 && (i.rd == i.rs1 || i.rd == i.rs2);
        if (!i.rst) begin
            if (m_state == 0) begin
                if (i.trap)       f = 8'b1000_1100;
                else if (i.busy)  f = 8'b1110_0000;
                else if (i.redir) begin f = 8'b0001_1010; t = i.tgt; end
                else if (lu)      f = 8'b1000_1000;
            end else if (m_state == 1) begin
                f = i.busy ? 8'b1110_0000 : 8'h00;
            end else if (m_state == 2) begin
                f = 8'b1000_1100;
            end else begin
                f = 8'b0001_1111; t = i.vec;
            end
        end
    endtask

    task automatic model_step(input in_t i, input bit stalled);
        if (i.rst) begin
            m_state = 0; m_drain_left = 0; m_epc = '0; m_cause = 4'd0; m_cnt = 0;
            return;
        end
        if (stalled) m_cnt++;
        case (m_state)
            0: if (i.trap) begin
                   m_epc = i.pc; m_cause = i.cause;
                   m_drain_left = DRAIN; m_state = 2;
               end else if (i.busy) m_state = 1;
            1: if (!i.busy) m_state = 0;
            2: if (!i.busy) begin
                   m_drain_left--;
                   if (m_drain_left == 0) m_state = 3;
               end
            default: m_state = 0;
        endcase
    endtask

    // One clock: drive, check combinational and registered outputs against
    // the model mid-cycle, then advance both across the edge.
    task automatic do_cycle(input in_t i);
        logic [7:0] ef;
        logic [XLEN-1:0] et;
        drive(i);
        #3;
        model_comb(i, ef, et);
        last_flags = {stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex, pc_load, trap_taken};
        last_tgt = pc_target;
        chk("flags", 64'(last_flags), 64'(ef));
        chk("pc_target", last_tgt, et);
        chk("state", 64'(state), 64'(m_state));
        chk("trap_epc", trap_epc, m_epc);
        chk("trap_cause", 64'(trap_cause_out), 64'(m_cause));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
        chk("stall_cycles_sat", 64'(s_stall_cycles), (m_cnt > 15) ? 64'd15 : 64'(m_cnt));
        model_step(i, ef[7]);
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        in_t i;
        vec_t v;
        int idx;
        int cnt;

        // Bring the DUT out of X before model checking starts.
        i = idle(); i.rst = 1'b1;
        drive(i);
        repeat (2) @(posedge clk);
        #1;
        m_state = 0; m_drain_left = 0; m_epc = '0; m_cause = 4'd0; m_cnt = 0;

        // Reset held with activity on the inputs: outputs must stay zero.
        i = idle(); i.rst = 1'b1; i.trap = 1'b1; i.redir = 1'b1; i.busy = 1'b1;
        do_cycle(i);
        chk("rst_flags", 64'(last_flags), 64'h0);
        chk("rst_tgt", last_tgt, 64'h0);

        // Single-cycle RUN vectors that leave the FSM in RUN.
        i = idle(); v.i = i; v.ef = 8'h00; v.et = '0; vt.push_back(v);
        i = idle(); i.mr = 1; i.rd = 5; i.rs2 = 5; v.i = i; v.ef = 8'b1000_1000; v.et = '0; vt.push_back(v);
        i = idle(); v.i = i; v.ef = 8'h00; v.et = '0; vt.push_back(v);
        i = idle(); i.mr = 1; i.rd = 0; i.rs1 = 0; v.i = i; v.ef = 8'h00; v.et = '0; vt.push_back(v);
        i = idle(); i.mr = 1; i.rd = 7; i.rs1 = 7; v.i = i; v.ef = 8'b1000_1000; v.et = '0; vt.push_back(v);
        i = idle(); i.mr = 0; i.rd = 7; i.rs1 = 7; v.i = i; v.ef = 8'h00; v.et = '0; vt.push_back(v);
        i = idle(); i.mr = 1; i.rd = 9; i.rs1 = 8; i.rs2 = 10; v.i = i; v.ef = 8'h00; v.et = '0; vt.push_back(v);
        i = idle(); i.redir = 1; i.tgt = 64'hDEAD_BEEF_0000_0040; v.i = i; v.ef = 8'b0001_1010; v.et = 64'hDEAD_BEEF_0000_0040; vt.push_back(v);
        i = idle(); i.redir = 1; i.tgt = 64'h88; i.mr = 1; i.rd = 4; i.rs1 = 4; v.i = i; v.ef = 8'b0001_1010; v.et = 64'h88; vt.push_back(v);
        foreach (vt[k]) begin
            do_cycle(vt[k].i);
            chk($sformatf("vec%0d_flags", k), 64'(last_flags), 64'(vt[k].ef));
            chk($sformatf("vec%0d_tgt", k), last_tgt, vt[k].et);
        end
        chk("loaduse_count", 64'(stall_cycles), 64'd2);

        // Trap with two drain cycles: entry, drain, drain, jump.
        i = idle(); i.trap = 1; i.cause = 4'd2; i.pc = 64'h80;
        do_cycle(i);
        chk("trap_entry", 64'(last_flags), 64'b1000_1100);
        do_cycle(idle()); chk("drain1", 64'(last_flags), 64'b1000_1100);
        do_cycle(idle()); chk("drain2", 64'(last_flags), 64'b1000_1100);
        do_cycle(idle()); chk("jump", 64'(last_flags), 64'b0001_1111);
        chk("jump_tgt", last_tgt, 64'h1000);
        do_cycle(idle()); chk("post_jump", 64'(last_flags), 64'h0);
        chk("epc", trap_epc, 64'h80);
        chk("cause", 64'(trap_cause_out), 64'd2);

        // Trap wins over mem_busy and redirect; busy in drain delays the jump.
        i = idle(); i.trap = 1; i.busy = 1; i.redir = 1; i.cause = 4'd5; i.pc = 64'h124;
        do_cycle(i);
        chk("simul_pc_load", 64'(last_flags[1]), 64'd0);
        idx = -1;
        for (int c = 1; c <= 12 && idx < 0; c++) begin
            i = idle(); i.busy = (c <= 3);
            do_cycle(i);
            if (last_flags[0]) idx = c;
        end
        chk("delayed_jump_cycle", 64'(idx), 64'd6);
        chk("epc_hold", trap_epc, 64'h124);

        // Memory wait with a redirect held throughout.
        idx = -1; cnt = 0;
        for (int c = 0; c < 10 && idx < 0; c++) begin
            i = idle(); i.redir = 1; i.tgt = 64'h5550; i.busy = (c < 4);
            do_cycle(i);
            if (last_flags[7]) cnt++;
            if (last_flags[1]) idx = c;
        end
        chk("memwait_stalls", 64'(cnt), 64'd4);
        chk("redirect_cycle", 64'(idx), 64'd5);
        chk("redirect_tgt", last_tgt, 64'h5550);

        // Reset in the middle of a drain.
        i = idle(); i.trap = 1; i.cause = 4'd9; i.pc = 64'h300;
        do_cycle(i);
        do_cycle(idle());
        i = idle(); i.rst = 1;
        do_cycle(i);
        chk("rst_mid_state", 64'(state), 64'd0);
        chk("rst_mid_epc", trap_epc, 64'h0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            do_cycle(idle());
            if (last_flags[0]) cnt++;
        end
        chk("no_trap_after_rst", 64'(cnt), 64'd0);

        // Saturation: 20 stall cycles on the 4-bit counter.
        i = idle(); i.rst = 1;
        do_cycle(i);
        for (int c = 0; c < 20; c++) begin
            i = idle(); i.mr = 1; i.rd = 6; i.rs1 = 6;
            do_cycle(i);
        end
        chk("sat_cnt4", 64'(s_stall_cycles), 64'd15);
        chk("cnt32_20", 64'(stall_cycles), 64'd20);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            i.rst   = ($urandom_range(0, 63) == 0);
            i.rs1   = 5'($urandom_range(0, 3));
            i.rs2   = 5'($urandom_range(0, 3));
            i.rd    = 5'($urandom_range(0, 3));
            i.mr    = ($urandom_range(0, 2) == 0);
            i.redir = ($urandom_range(0, 3) == 0);
            i.trap  = ($urandom_range(0, 15) == 0);
            i.busy  = ($urandom_range(0, 4) == 0);
            i.tgt   = {$urandom, $urandom};
            i.pc    = {$urandom, $urandom};
            i.vec   = {$urandom, $urandom};
            i.cause = 4'($urandom_range(0, 15));
            do_cycle(i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
